// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer producing HI/LO write data.
// Define MDU_DIV_ZERO_SKIP_EN to retire divide-by-zero one cycle after accept.
module mdu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [1:0]  op_kind,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall_o,
    output logic        hilo_we,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy_o
);
    typedef enum logic [2:0] {IDLE, MUL, DIV, SIGN, DONE} state_e;
    state_e state_q, state_d;
    logic [1:0] op_q, op_d;
    logic sa_q, sa_d, sb_q, sb_d;
    logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [4:0] cnt_q, cnt_d;
    logic accept, is_signed;
    logic [31:0] abs_a, abs_b;
    logic [63:0] prod;
    logic [32:0] trial;
    assign accept = state_q == IDLE && req_valid && !flush && !rst;
    assign is_signed = !op_kind[0];
    assign abs_a = (is_signed && src_a[31]) ? -src_a : src_a;
    assign abs_b = (is_signed && src_b[31]) ? -src_b : src_b;
    assign prod = {32'd0, a_q} * {32'd0, b_q};
    // While dividing, hi_q is the partial remainder and lo_q shifts dividend out / quotient in.
    assign trial = {hi_q, lo_q[31]} - {1'b0, b_q};
    assign hilo_we = state_q == DONE && !flush;
    assign busy_o = state_q != IDLE;
    assign hi_o = hi_q;
    assign lo_o = lo_q;
    always_comb begin
        state_d = state_q;
        op_d = op_q;
        sa_d = sa_q;
        sb_d = sb_q;
        a_d = a_q;
        b_d = b_q;
        hi_d = hi_q;
        lo_d = lo_q;
        cnt_d = cnt_q;
        stall_o = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                stall_o = 1'b1;
                op_d = op_kind;
                sa_d = is_signed & src_a[31];
                sb_d = is_signed & src_b[31];
                a_d = abs_a;
                b_d = abs_b;
                hi_d = '0;
                lo_d = abs_a;
                cnt_d = '0;
                state_d = op_kind[1] ? DIV : MUL;
`ifdef MDU_DIV_ZERO_SKIP_EN
                if (op_kind[1] && src_b == '0) begin
                    hi_d = src_a;
                    lo_d = '1;
                    state_d = DONE;
                end
`endif
            end
            MUL: begin
                stall_o = 1'b1;
                {hi_d, lo_d} = (!op_q[0] && (sa_q ^ sb_q)) ? -prod : prod;
                state_d = DONE;
            end
            DIV: begin
                stall_o = 1'b1;
                hi_d = trial[32] ? {hi_q[30:0], lo_q[31]} : trial[31:0];
                lo_d = {lo_q[30:0], ~trial[32]};
                cnt_d = cnt_q + 5'd1;
                state_d = (cnt_q == 5'd31) ? SIGN : DIV;
            end
            SIGN: begin
                stall_o = 1'b1;
                lo_d = (op_q == 2'b10 && (sa_q ^ sb_q)) ? -lo_q : lo_q;
                hi_d = (op_q == 2'b10 && sa_q) ? -hi_q : hi_q;
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q <= '0;
            sa_q <= 1'b0;
            sb_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            sa_q <= sa_d;
            sb_q <= sb_d;
            a_q <= a_d;
            b_q <= b_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed bench for mdu_ctrl; expected HI/LO and write cycle queued at issue.
module tb_mdu_ctrl;
    logic clk = 1'b0;
    logic rst, req_valid, flush;
    logic [1:0] op_kind;
    logic [31:0] src_a, src_b;
    logic stall_o, hilo_we, busy_o;
    logic [31:0] hi_o, lo_o;
    int cyc = 0;
    int errors = 0;
    int checks = 0;
    typedef struct {logic [31:0] hi; logic [31:0] lo; int due;} exp_t;
    exp_t sb[$];
    exp_t e;
    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;
`ifdef MDU_DIV_ZERO_SKIP_EN
    localparam int DZ_LAT = 1;
`else
    localparam int DZ_LAT = 34;
`endif

    mdu_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .op_kind(op_kind),
        .src_a(src_a), .src_b(src_b), .flush(flush), .stall_o(stall_o),
        .hilo_we(hilo_we), .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int lat, input bit push);
        req_valid = 1'b1;
        op_kind = op;
        src_a = a;
        src_b = b;
        if (push) sb.push_back('{eh, el, cyc + lat});
        #1 chk("accept_stall", {63'd0, stall_o}, 64'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit && (busy_o || sb.size() != 0); i++) tick();
        chk("drain", {62'd0, busy_o, sb.size() != 0}, 64'd0);
    endtask

    always @(negedge clk) begin
        if (hilo_we === 1'b1) begin
            chk("expected_write", {63'd0, sb.size() != 0}, 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("we_cycle", 64'(cyc), 64'(e.due));
                chk("hi", {32'd0, hi_o}, {32'd0, e.hi});
                chk("lo", {32'd0, lo_o}, {32'd0, e.lo});
            end
        end
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b1;
        flush = 1'b0;
        op_kind = DIV;
        src_a = 32'd9;
        src_b = 32'd2;
        tick();
        tick();
        chk("reset_outs", {28'd0, stall_o, hilo_we, busy_o, hi_o, lo_o}, 64'd0);
        rst = 1'b0;
        req_valid = 1'b0;
        tick();
        chk("reset_idle", {63'd0, busy_o}, 64'd0);

        issue(MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 2, 1);
        chk("mul_stall_c1", {63'd0, stall_o}, 64'd1);
        tick();
        chk("mul_stall_done", {62'd0, stall_o, hilo_we}, 64'd1);
        tick();
        chk("mul_idle", {62'd0, stall_o, busy_o}, 64'd0);

        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2, 1);
        wait_idle(10);
        issue(MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 2, 1);
        wait_idle(10);

        issue(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 1);
        wait_idle(50);
        issue(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 34, 1);
        wait_idle(50);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 34, 1);
        wait_idle(50);
        issue(DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 34, 1);
        wait_idle(50);
        issue(DIVU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'h7FFF_FFFF, 34, 1);
        wait_idle(50);
        issue(DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, DZ_LAT, 1);
        wait_idle(50);

        // Flush a divide in flight, then accept a multiply right behind it.
        issue(DIVU, 32'd1000, 32'd3, 32'd0, 32'd0, 0, 0);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_idle", {61'd0, busy_o, stall_o, hilo_we}, 64'd0);
        issue(MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 2, 1);
        wait_idle(10);

        issue(MULTU, 32'd3, 32'd4, 32'd0, 32'd0, 0, 0);
        tick();
        flush = 1'b1;
        #1 chk("flush_done_we", {63'd0, hilo_we}, 64'd0);
        tick();
        flush = 1'b0;
        chk("flush_done_idle", {63'd0, busy_o}, 64'd0);

        issue(MULTU, 32'd9, 32'd9, 32'd0, 32'd81, 2, 1);
        tick();
        req_valid = 1'b1;
        op_kind = DIVU;
        #1 chk("done_no_accept", {63'd0, stall_o}, 64'd0);
        tick();
        req_valid = 1'b0;
        chk("done_no_accept_idle", {63'd0, busy_o}, 64'd0);

        issue(DIV, 32'd100, 32'd3, 32'd0, 32'd0, 0, 0);
        repeat (4) tick();
        rst = 1'b1;
        req_valid = 1'b1;
        op_kind = MULT;
        tick();
        chk("rst_mid_outs", {28'd0, stall_o, hilo_we, busy_o, hi_o, lo_o}, 64'd0);
        tick();
        rst = 1'b0;
        req_valid = 1'b0;
        #1 chk("rst_no_accept", {63'd0, busy_o}, 64'd0);
        repeat (3) tick();
        wait_idle(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port req_valid, input, 1 bit: the execute stage holds a HI/LO-producing mult/div op.
REQ-004 SHALL have port op_kind, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have ports src_a and src_b, input, 32 bits each: rs/rt operand values.
REQ-006 SHALL have port flush, input, 1 bit: pipeline flush (exception/eret) that cancels any in-flight op.
REQ-007 SHALL have port stall_o, output, 1 bit: holds the front pipeline while the op is in progress.
REQ-008 SHALL have port hilo_we, output, 1 bit: one-cycle HI/LO write strobe.
REQ-009 SHALL have ports hi_o and lo_o, output, 32 bits each: HI/LO write data, valid while hilo_we=1.
REQ-010 SHALL have port busy_o, output, 1 bit: high whenever state is not IDLE.

Function
REQ-011 SHALL implement the states IDLE, MUL, DIV, SIGN and DONE, encoded as one state register.
REQ-012 SHALL accept a request in IDLE when req_valid=1 and flush=0, latching op_kind, the operand sign flags and the absolute operand values (absolute only for signed ops).
REQ-013 SHALL make stall_o combinational: 1 in IDLE on an accept cycle, 1 in MUL, DIV and SIGN, and 0 in IDLE without an accept and in DONE.
REQ-014 SHALL transition on accept of MULT/MULTU to MUL; MUL shall register the 64-bit product (signed for MULT) and go to DONE, so hilo_we fires 2 cycles after accept.
REQ-015 SHALL transition on accept of DIV/DIVU to DIV and run a restoring unsigned divide, 1 quotient bit per cycle, over exactly 32 cycles using a 5-bit counter that wraps 31->0 to exit.
REQ-016 SHALL go from DIV to SIGN, which negates the quotient if the operand signs differ (DIV only) and negates the remainder if the dividend is negative (DIV only), then go to DONE; hilo_we fires 34 cycles after accept.
REQ-017 SHALL apply 32-bit wrap to all arithmetic: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
REQ-018 SHALL place the high product word or the remainder on hi_o, and the low product word or the quotient on lo_o.
REQ-019 SHALL assert hilo_we = (state==DONE) & ~flush, then go from DONE to IDLE unconditionally; req_valid seen in DONE shall not be accepted.
REQ-020 SHALL return to IDLE on the next edge whenever flush=1 in any state, with no hilo_we for the cancelled op.
REQ-021 SHALL produce, for divide by zero without the macro, the natural restoring result: quotient 0xFFFFFFFF, remainder |src_a|, followed by the normal sign fix.

Reset
REQ-022 SHALL, on rst=1 at a clock edge, set state=IDLE, counter=0 and clear the operand/result registers, giving stall_o=0, hilo_we=0, hi_o=0, lo_o=0 and busy_o=0.
REQ-023 SHALL let rst override flush and req_valid; a reset mid-operation abandons the op with no hilo_we.

Configuration
REQ-024 SHALL provide the macro MDU_DIV_ZERO_SKIP_EN: when defined, a DIV/DIVU accepted with src_b=0 goes directly to DONE with hi_o=src_a and lo_o=0xFFFFFFFF, so hilo_we fires 1 cycle after accept and stall_o is high only on the accept cycle.
REQ-025 SHALL, when MDU_DIV_ZERO_SKIP_EN is undefined, time divide by zero exactly as any other divide (34 cycles) and produce results per REQ-021.

Verification
REQ-026 SHALL cover MULT with a=0xFFFFFFFE (-2), b=3 -> hilo_we at accept+2, hi=0xFFFFFFFF, lo=0xFFFFFFFA, stall_o high for exactly 2 cycles.
REQ-027 SHALL cover MULTU with a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-028 SHALL cover DIV with a=-7 (0xFFFFFFF9), b=2 -> hilo_we at accept+34, lo=0xFFFFFFFD, hi=0xFFFFFFFF; also DIVU with a=100, b=7 -> lo=14, hi=2.
REQ-029 SHALL cover flush asserted at accept+10 of a DIVU -> state IDLE next cycle, no hilo_we, stall_o=0, and a new MULTU accepted on the following cycle completes normally.
REQ-030 SHALL cover DIV with a=5, b=0 -> with the macro: hilo_we at accept+1, hi=5, lo=0xFFFFFFFF; without it: hilo_we at accept+34, hi=5, lo=0xFFFFFFFF.
REQ-031 SHALL cover rst asserted at accept+5 of a DIV -> all outputs 0 next cycle, and req_valid held high together with rst is not accepted.
